// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
// bam_model is a plain bit-level reference of the retained partial-product sum.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bam_state_e;

    function automatic int h_cfg_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int v_cfg_w(input int width);
        return $clog2(2 * width + 1);
    endfunction

    function automatic longint unsigned bam_model(input longint unsigned a,
                                                  input longint unsigned b,
                                                  input int width,
                                                  input int h,
                                                  input int v);
        longint unsigned acc;
        acc = 0;
        for (int j = 0; j < width; j++) begin
            for (int i = 0; i < width; i++) begin
                if (j >= h && (i + j) >= v && a[i] && b[j])
                    acc += 64'd1 << (i + j);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bam_row_mask.sv
// One partial-product row of the broken array: a & b_bit, with every column
// below the vertical break forced to zero.
module bam_row_mask
    import bam_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RW    = 4,
    parameter int VW    = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_bit_i,
    input  logic [RW-1:0]    row_i,
    input  logic [VW-1:0]    v_i,
    output logic [WIDTH-1:0] mrow_o
);

    always_comb begin
        mrow_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mrow_o[i] = a_i[i] & b_bit_i & ((i + int'(row_i)) >= int'(v_i));
        end
    end

endmodule

// File: rtl/u_arrbam_seq.sv
// Sequential broken-array multiplier: adds one masked partial-product row per clock.
// Define BAM_RUNTIME_BREAK_EN to replace H_BREAK/V_BREAK with h_cfg/v_cfg ports.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | adding rows h..WIDTH-1, one per clock
// DONE  | out_valid=1, p held until out_ready
module u_arrbam_seq
    import bam_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int H_BREAK = 3,
    parameter int V_BREAK = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WIDTH-1:0]        p
`ifdef BAM_RUNTIME_BREAK_EN
    ,
    input  logic [h_cfg_w(WIDTH)-1:0] h_cfg,
    input  logic [v_cfg_w(WIDTH)-1:0] v_cfg
`endif
);

    localparam int HW = h_cfg_w(WIDTH);
    localparam int VW = v_cfg_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    bam_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [HW-1:0]    row_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    p_q;
    logic             out_valid_q;
    logic [HW-1:0]    h_eff;
    logic [VW-1:0]    v_row;
    logic             b_bit;
    logic [WIDTH-1:0] mrow;

`ifdef BAM_RUNTIME_BREAK_EN
    logic [VW-1:0] v_eff;
    logic [VW-1:0] v_q;

    always_comb begin
        h_eff = (int'(h_cfg) > WIDTH) ? HW'(WIDTH) : h_cfg;
        v_eff = (int'(v_cfg) > PW) ? VW'(PW) : v_cfg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v_q <= '0;
        else if (state_q == IDLE && in_valid)
            v_q <= v_eff;
    end

    assign v_row = v_q;
`else
    assign h_eff = HW'(H_BREAK);
    assign v_row = VW'(V_BREAK);
`endif

    // row_q == WIDTH (h saturated) selects no b bit, so that RUN cycle adds zero
    assign b_bit = |(b_q & (WIDTH'(1) << row_q));

    bam_row_mask #(
        .WIDTH (WIDTH),
        .RW    (HW),
        .VW    (VW)
    ) u_row_mask (
        .a_i     (a_q),
        .b_bit_i (b_bit),
        .row_i   (row_q),
        .v_i     (v_row),
        .mrow_o  (mrow)
    );

    assign acc_d = acc_q + (PW'(mrow) << row_q);

    // h >= WIDTH still passes through one empty RUN cycle so latency is never zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        row_q   <= h_eff;
                        acc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    row_q <= row_q + 1'b1;
                    if (int'(row_q) >= WIDTH - 1) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        p_q         <= acc_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule
